// File: rtl/sync_arith_pkg.sv
// Shared types and constants for the arithmetic command issuer.
package sync_arith_pkg;

    // Operand width of the command payload; must match the ALU operand width.
    localparam int PKG_BITS = 32;

    // Op code of the single-operand ALU operation; its B operand is never used.
    localparam logic [1:0] OP_UNARY = 2'd2;

    typedef struct packed {
        logic [PKG_BITS-1:0] a;
        logic [PKG_BITS-1:0] b;
        logic [1:0]          op;
    } cmd_t;

    // Build a stored command; unary ops carry a zero B so stale data never reaches the ALU.
    function automatic cmd_t make_cmd(input logic [PKG_BITS-1:0] a,
                                      input logic [PKG_BITS-1:0] b,
                                      input logic [1:0]          op);
        cmd_t c;
        c.a  = a;
        c.b  = (op == OP_UNARY) ? {PKG_BITS{1'b0}} : b;
        c.op = op;
        return c;
    endfunction

endpackage

// File: rtl/sync_arith_cmd_fifo.sv
// Register-based command FIFO. Pointers carry an extra wrap bit so that
// full and empty are distinguishable when the index bits match.
module sync_arith_cmd_fifo
    import sync_arith_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wr,
    input  cmd_t                     i_wr_data,
    input  logic                     i_rd,
    input  logic                     i_flush,
    output cmd_t                     o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    cmd_t            mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic            wr_wrap_r;
    logic            rd_wrap_r;
    logic [AW:0]     level_r;
    logic            full_s;
    logic            empty_s;
    logic            wr_en_s;
    logic            rd_en_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r) && (wr_wrap_r == rd_wrap_r);
    assign full_s  = (wr_ptr_r == rd_ptr_r) && (wr_wrap_r != rd_wrap_r);

    // Overflow and underflow are impossible even if a caller misbehaves; flush suppresses both.
    assign wr_en_s = i_wr & ~full_s & ~i_flush;
    assign rd_en_s = i_rd & ~empty_s & ~i_flush;

    assign o_rd_data = mem_r[rd_ptr_r];
    assign o_full    = full_s;
    assign o_empty   = empty_s;
    assign o_level   = level_r;

    // Storage array: written at the write pointer on an accepted write.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush returns everything to the empty state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            wr_wrap_r <= 1'b0;
            rd_wrap_r <= 1'b0;
            level_r   <= '0;
        end else if (i_flush) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            wr_wrap_r <= 1'b0;
            rd_wrap_r <= 1'b0;
            level_r   <= '0;
        end else begin
            if (wr_en_s) begin
                {wr_wrap_r, wr_ptr_r} <= {wr_wrap_r, wr_ptr_r} + {{AW{1'b0}}, 1'b1};
            end
            if (rd_en_s) begin
                {rd_wrap_r, rd_ptr_r} <= {rd_wrap_r, rd_ptr_r} + {{AW{1'b0}}, 1'b1};
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/sync_arith_cmd_issuer.sv
// Command issuer in front of the synchronous ALU: buffers valid/ready commands,
// issues at most one per cycle into registered ALU arguments, and delays the
// issue strobe by the ALU latency to flag cycles carrying real results.
module sync_arith_cmd_issuer
    import sync_arith_pkg::*;
#(
    parameter int BITS    = 32,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [BITS-1:0]         i_cmd_A,
    input  logic [BITS-1:0]         i_cmd_B,
    input  logic [1:0]              i_cmd_op,
    input  logic                    i_hold,
    input  logic                    i_flush,
    output logic [BITS-1:0]         o_arg_A,
    output logic [BITS-1:0]         o_arg_B,
    output logic [1:0]              o_op,
    output logic                    o_issue,
    output logic                    o_res_valid,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic [15:0]             o_issue_cnt
);

    logic               full_s;
    logic               empty_s;
    logic               ready_s;
    logic               wr_s;
    logic               pop_s;
    cmd_t               wr_data_s;
    cmd_t               head_s;
    logic [BITS-1:0]    arg_a_r;
    logic [BITS-1:0]    arg_b_r;
    logic [1:0]         op_r;
    logic               issue_r;
    logic [15:0]        issue_cnt_r;
    logic [ALU_LAT-1:0] res_sr_r;

    // Ready is held low during reset and during a flush cycle; a full FIFO refuses even if it pops now.
    assign ready_s   = i_reset & ~full_s & ~i_flush;
    assign wr_s      = i_cmd_valid & ready_s;
    assign pop_s     = ~empty_s & ~i_hold & ~i_flush;
    assign wr_data_s = make_cmd(i_cmd_A, i_cmd_B, i_cmd_op);

    sync_arith_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr      (wr_s),
        .i_wr_data (wr_data_s),
        .i_rd      (pop_s),
        .i_flush   (i_flush),
        .o_rd_data (head_s),
        .o_full    (full_s),
        .o_empty   (empty_s),
        .o_level   (o_level)
    );

    // Issue stage: pop the head into the ALU argument registers and count issued commands.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            arg_a_r     <= '0;
            arg_b_r     <= '0;
            op_r        <= 2'd0;
            issue_r     <= 1'b0;
            issue_cnt_r <= 16'd0;
        end else if (pop_s) begin
            arg_a_r     <= head_s.a;
            arg_b_r     <= head_s.b;
            op_r        <= head_s.op;
            issue_r     <= 1'b1;
            issue_cnt_r <= issue_cnt_r + 16'd1;
        end else begin
            issue_r     <= 1'b0;
        end
    end

    // Result-valid delay line; flush leaves it alone because the ALU is already computing those results.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            res_sr_r <= '0;
        end else begin
            res_sr_r[0] <= issue_r;
            for (int i = 1; i < ALU_LAT; i++) begin
                res_sr_r[i] <= res_sr_r[i-1];
            end
        end
    end

    assign o_cmd_ready = ready_s;
    assign o_arg_A     = arg_a_r;
    assign o_arg_B     = arg_b_r;
    assign o_op        = op_r;
    assign o_issue     = issue_r;
    assign o_res_valid = res_sr_r[ALU_LAT-1];
    assign o_issue_cnt = issue_cnt_r;

endmodule

// File: tb/tb_sync_arith_cmd_issuer.sv
// Self-checking bench for sync_arith_cmd_issuer: a queue-based reference model
// checked every cycle, plus directed literal expectations.
module tb_sync_arith_cmd_issuer;

    localparam int BITS  = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [BITS-1:0]   cmd_a = '0;
    logic [BITS-1:0]   cmd_b = '0;
    logic [1:0]        cmd_op = 2'd0;
    logic              hold = 1'b0;
    logic              flush = 1'b0;
    logic [BITS-1:0]   arg_a;
    logic [BITS-1:0]   arg_b;
    logic [1:0]        op;
    logic              issue;
    logic              res_valid;
    logic [2:0]        level;
    logic [15:0]       issue_cnt;

    sync_arith_cmd_issuer #(
        .BITS    (BITS),
        .DEPTH   (DEPTH),
        .ALU_LAT (LAT)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_A     (cmd_a),
        .i_cmd_B     (cmd_b),
        .i_cmd_op    (cmd_op),
        .i_hold      (hold),
        .i_flush     (flush),
        .o_arg_A     (arg_a),
        .o_arg_B     (arg_b),
        .o_op        (op),
        .o_issue     (issue),
        .o_res_valid (res_valid),
        .o_level     (level),
        .o_issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [1:0]      op;
    } mcmd_t;

    mcmd_t           mq[$];
    bit              issue_at[int];
    int              cyc = 0;
    logic            exp_issue;
    logic [BITS-1:0] exp_a;
    logic [BITS-1:0] exp_b;
    logic [1:0]      exp_op;
    logic [15:0]     exp_cnt;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        issue_at.delete();
        exp_issue = 1'b0;
        exp_a     = '0;
        exp_b     = '0;
        exp_op    = 2'd0;
        exp_cnt   = 16'd0;
    endtask

    // One clock edge of the behaviour: accept, pop, flush, count.
    task automatic model_step();
        bit    push;
        bit    pop;
        mcmd_t h;
        mcmd_t n;
        cyc++;
        if (issue_at.exists(cyc - LAT - 1)) issue_at.delete(cyc - LAT - 1);
        if (!rst_n) begin
            model_clear();
            return;
        end
        push = cmd_valid && (mq.size() < DEPTH) && !flush;
        pop  = (mq.size() > 0) && !hold && !flush;
        if (pop) begin
            h = mq.pop_front();
            exp_issue = 1'b1;
            exp_a     = h.a;
            exp_b     = h.b;
            exp_op    = h.op;
            exp_cnt   = exp_cnt + 16'd1;
            issue_at[cyc] = 1'b1;
        end else begin
            exp_issue = 1'b0;
        end
        if (push) begin
            n.a  = cmd_a;
            n.b  = (cmd_op == 2'd2) ? '0 : cmd_b;
            n.op = cmd_op;
            mq.push_back(n);
        end
        if (flush) mq.delete();
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("issue", issue, exp_issue);
        chk("res_valid", res_valid, issue_at.exists(cyc - LAT));
        chk("level", level, mq.size());
        chk("ready", cmd_ready, rst_n && (mq.size() < DEPTH) && !flush);
        chk("issue_cnt", issue_cnt, exp_cnt);
        chk("arg_a", arg_a, exp_a);
        chk("arg_b", arg_b, exp_b);
        chk("op", op, exp_op);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input logic [1:0] o);
        cmd_valid = v;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = o;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        hold      = 1'b0;
        flush     = 1'b0;
    endtask

    int acc;
    int iter;

    initial begin
        model_clear();
        tick();
        tick();
        // Reset state
        chk("rst_issue", issue, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_cnt", issue_cnt, 16'd0);
        rst_n = 1'b1;

        // 1: basic issue and result-valid latency
        drive(1'b1, 32'd5, 32'd3, 2'd0);
        tick();
        chk("t1_level", level, 3'd1);
        chk("t1_no_issue", issue, 1'b0);
        idle();
        tick();
        chk("t1_issue", issue, 1'b1);
        chk("t1_arg_a", arg_a, 32'd5);
        chk("t1_arg_b", arg_b, 32'd3);
        chk("t1_cnt", issue_cnt, 16'd1);
        tick();
        chk("t1_res_early", res_valid, 1'b0);
        tick();
        chk("t1_res", res_valid, 1'b1);
        chk("t1_arg_hold", arg_a, 32'd5);

        // 2: unary op zeroes B
        drive(1'b1, 32'h1234, 32'hFFFF, 2'd2);
        tick();
        idle();
        tick();
        chk("t2_issue", issue, 1'b1);
        chk("t2_arg_a", arg_a, 32'h1234);
        chk("t2_arg_b", arg_b, 32'd0);
        chk("t2_op", op, 2'd2);

        // 3: hold fills FIFO, fifth command refused, then ordered drain
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + i, 32'h20 + i, (i == 2) ? 2'd3 : 2'(i));
            tick();
        end
        drive(1'b1, 32'h99, 32'h98, 2'd1);
        chk("t3_level_full", level, 3'd4);
        chk("t3_ready_full", cmd_ready, 1'b0);
        tick();
        chk("t3_fifth_refused", level, 3'd4);
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_drain_issue", issue, 1'b1);
            chk("t3_drain_a", arg_a, 32'h10 + i);
            chk("t3_drain_b", arg_b, 32'h20 + i);
            chk("t3_drain_level", level, 3 - i);
        end
        tick();
        chk("t3_empty_no_issue", issue, 1'b0);

        // 4: flush of a full FIFO with a simultaneous write; pending strobe survives
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40 + i, 32'h0, 2'd0);
            tick();
        end
        idle();
        tick();
        chk("t4_pop_issue", issue, 1'b1);
        chk("t4_pop_a", arg_a, 32'h40);
        chk("t4_pop_level", level, 3'd3);
        hold = 1'b1;
        drive(1'b1, 32'h50, 32'h0, 2'd0);
        tick();
        chk("t4_refill", level, 3'd4);
        flush = 1'b1;
        drive(1'b1, 32'hBB, 32'h0, 2'd0);
        chk("t4_ready_flush", cmd_ready, 1'b0);
        tick();
        chk("t4_flush_level", level, 3'd0);
        chk("t4_flush_issue", issue, 1'b0);
        chk("t4_res_survives", res_valid, 1'b1);
        idle();
        tick();
        chk("t4_nothing_stored", issue, 1'b0);
        chk("t4_level_after", level, 3'd0);

        // 6: asynchronous reset mid-stream with results pending
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h60 + i, 32'h70 + i, 2'd1);
            tick();
        end
        chk("t6_streaming", issue, 1'b1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("t6_rst_issue", issue, 1'b0);
        chk("t6_rst_res", res_valid, 1'b0);
        chk("t6_rst_arg_a", arg_a, 32'd0);
        chk("t6_rst_level", level, 3'd0);
        chk("t6_rst_cnt", issue_cnt, 16'd0);
        chk("t6_rst_ready", cmd_ready, 1'b0);
        tick();
        tick();
        chk("t6_ready_in_rst", cmd_ready, 1'b0);
        idle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_res_after", res_valid, 1'b0);
        end

        // 5: 65537 issues, pointer wrap with intermittent hold, counter wraps to 1
        acc  = 0;
        iter = 0;
        while (acc < 65537) begin
            drive(1'b1, 32'(acc), ~32'(acc), 2'(acc % 4));
            hold = ((iter % 97) < 3);
            if (mq.size() < DEPTH) acc++;
            tick();
            iter++;
        end
        idle();
        for (int t = 0; t < 20 && (mq.size() != 0 || exp_issue); t++) begin
            tick();
        end
        chk("t5_drained_level", level, 3'd0);
        chk("t5_drained_issue", issue, 1'b0);
        chk("t5_cnt_wrap", issue_cnt, 16'd1);
        tick();
        tick();
        tick();
        chk("t5_res_quiet", res_valid, 1'b0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
